// File: rtl/i2c_eeprom_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_eeprom_resp_pkg
// Description : Shared types for the on-chip I2C EEPROM responder: protocol
//               state enumeration, bus-condition codes and the default
//               7-bit device address.
// Revision    : 1.0  initial release
// ============================================================================
package i2c_eeprom_resp_pkg;

  // Protocol states of the responder
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEVADDR = 4'd1,
    S_ACK_DEV = 4'd2,
    S_ADDR_HI = 4'd3,
    S_ACK_HI  = 4'd4,
    S_ADDR_LO = 4'd5,
    S_ACK_LO  = 4'd6,
    S_WDATA   = 4'd7,
    S_ACK_W   = 4'd8,
    S_RDATA   = 4'd9,
    S_MACK    = 4'd10
  } state_t;

  // Bus conditions seen on the filtered lines
  typedef enum logic [1:0] {
    COND_NONE  = 2'd0,
    COND_START = 2'd1,
    COND_STOP  = 2'd2
  } cond_t;

  localparam logic [6:0] C_DEV_ADDR_DEFAULT = 7'h50;

endpackage
`default_nettype wire

// File: rtl/i2c_in_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_in_filter
// Description : Two-flop synchroniser followed by a stability filter for one
//               I2C line. A new level is accepted only after the synchronised
//               value has differed from the accepted level for FILTER clocks.
//               Pin-to-event latency is 2+FILTER clocks.
// Ports       : clk     - system clock
//               res     - asynchronous active-high reset (level resets to 1)
//               i_pin   - raw line level
//               o_level - filtered level
//               o_rise  - one-clock pulse when o_level goes 0->1
//               o_fall  - one-clock pulse when o_level goes 1->0
// Revision    : 1.0  initial release
// ============================================================================
module i2c_in_filter #(
  parameter int FILTER = 3
) (
  input  logic clk,
  input  logic res,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          w_diff;
  logic          w_done;

  assign w_diff = (r_sync[1] != r_level);
  assign w_done = w_diff && (r_cnt == CW'(FILTER - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_rise <= w_done &&  r_sync[1];
      r_fall <= w_done && !r_sync[1];
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/i2c_eeprom_resp.sv
`default_nettype none
// ============================================================================
// Module      : i2c_eeprom_resp
// Description : I2C EEPROM responder (24LC256-compatible command set) backed
//               by an external synchronous byte RAM. Supports byte and
//               multi-byte writes, random, sequential and current-address
//               reads. The address pointer wraps over the full ADDR_BITS
//               space and survives between transactions.
// Ports       : clk       - system clock (>= 16x SCL rate)
//               res       - asynchronous active-high reset
//               scl_in    - resolved SCL level
//               sda_in    - resolved SDA level (includes our own pull-down)
//               sda_oe    - 1 = pull SDA low
//               busy      - device addressed
//               mem_addr  - RAM address pointer
//               mem_rdata - RAM read data, valid 1 clk after mem_addr
//               mem_wdata - RAM write data
//               mem_we    - one-clock RAM write strobe
// Revision    : 1.0  initial release
// ============================================================================
module i2c_eeprom_resp
  import i2c_eeprom_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = C_DEV_ADDR_DEFAULT,
  parameter int         ADDR_BITS = 15,   // supported range 9..16
  parameter int         FILTER    = 3,
  parameter bit         WRITE_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we
);

  localparam int HW = ADDR_BITS - 8;  // address bits kept from the high byte

  // Filtered line events
  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_in_filter #(.FILTER(FILTER)) u_scl_filt (
    .clk     (clk),
    .res     (res),
    .i_pin   (scl_in),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_in_filter #(.FILTER(FILTER)) u_sda_filt (
    .clk     (clk),
    .res     (res),
    .i_pin   (sda_in),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // Both filters share the same latency, so the SCL level seen here is the
  // one that was on the pin when SDA moved.
  cond_t w_cond;
  always_comb begin
    w_cond = COND_NONE;
    if (w_scl && w_sda_fall)      w_cond = COND_START;
    else if (w_scl && w_sda_rise) w_cond = COND_STOP;
  end

  // Registers
  state_t               r_state;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_rw;
  logic [HW-1:0]        r_hi;
  logic [ADDR_BITS-1:0] r_ptr;
  logic                 r_sda_oe;
  logic                 r_busy;
  logic                 r_we;
  logic [7:0]           r_wdata;
  logic                 r_inc;      // bump the pointer on the next clock
  logic                 r_mack_ok;  // master acknowledged the last read byte

  // Next-state values
  state_t               w_state_nxt;
  logic [2:0]           w_bit_nxt;
  logic [7:0]           w_shift_nxt;
  logic                 w_rw_nxt;
  logic [HW-1:0]        w_hi_nxt;
  logic [ADDR_BITS-1:0] w_ptr_nxt;
  logic                 w_oe_nxt;
  logic                 w_busy_nxt;
  logic                 w_we_nxt;
  logic [7:0]           w_wdata_nxt;
  logic                 w_inc_nxt;
  logic                 w_mack_nxt;
  logic [7:0]           w_byte;

  // Byte as it stands once the current SDA level is shifted in
  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_hi      <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_inc     <= 1'b0;
      r_mack_ok <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_rw      <= w_rw_nxt;
      r_hi      <= w_hi_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_oe  <= w_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_we      <= w_we_nxt;
      r_wdata   <= w_wdata_nxt;
      r_inc     <= w_inc_nxt;
      r_mack_ok <= w_mack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_rw_nxt    = r_rw;
    w_hi_nxt    = r_hi;
    w_ptr_nxt   = r_inc ? (r_ptr + ADDR_BITS'(1)) : r_ptr;
    w_oe_nxt    = r_sda_oe;
    w_busy_nxt  = r_busy;
    w_we_nxt    = 1'b0;
    w_wdata_nxt = r_wdata;
    w_inc_nxt   = 1'b0;
    w_mack_nxt  = r_mack_ok;

    case (w_cond)
      COND_START: begin
        w_state_nxt = S_DEVADDR;
        w_bit_nxt   = '0;
        w_oe_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_mack_nxt  = 1'b0;
      end
      COND_STOP: begin
        w_state_nxt = S_IDLE;
        w_bit_nxt   = '0;
        w_oe_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_mack_nxt  = 1'b0;
      end
      default: begin
        case (r_state)
          S_IDLE: ;

          // Receive a byte from the master, MSB first
          S_DEVADDR, S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
            if (w_scl_rise) begin
              w_shift_nxt = w_byte;
              w_bit_nxt   = r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                case (r_state)
                  S_DEVADDR: begin
                    if (w_byte[7:1] == DEV_ADDR) begin
                      w_state_nxt = S_ACK_DEV;
                      w_busy_nxt  = 1'b1;
                      w_rw_nxt    = w_byte[0];
                    end else begin
                      w_state_nxt = S_IDLE;
                    end
                  end
                  S_ADDR_HI: begin
                    w_hi_nxt    = w_byte[HW-1:0];
                    w_state_nxt = S_ACK_HI;
                  end
                  S_ADDR_LO: begin
                    w_ptr_nxt   = {r_hi, w_byte};
                    w_state_nxt = S_ACK_LO;
                  end
                  default: begin  // S_WDATA
                    if (WRITE_EN) begin
                      w_wdata_nxt = w_byte;
                      w_we_nxt    = 1'b1;
                      w_inc_nxt   = 1'b1;
                      w_state_nxt = S_ACK_W;
                    end else begin
                      w_state_nxt = S_IDLE;
                      w_busy_nxt  = 1'b0;
                    end
                  end
                endcase
              end
            end
          end

          // First falling edge asserts the ACK, the next one releases it
          S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_W: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                w_oe_nxt = 1'b1;
              end else begin
                w_oe_nxt  = 1'b0;
                w_bit_nxt = '0;
                case (r_state)
                  S_ACK_DEV: begin
                    if (r_rw) begin
                      w_state_nxt = S_RDATA;
                      w_shift_nxt = mem_rdata;
                      w_oe_nxt    = ~mem_rdata[7];
                      w_inc_nxt   = 1'b1;
                    end else begin
                      w_state_nxt = S_ADDR_HI;
                    end
                  end
                  S_ACK_HI: w_state_nxt = S_ADDR_LO;
                  default:  w_state_nxt = S_WDATA;
                endcase
              end
            end
          end

          // Drive the byte out; bit 7 of the shift register is on the line
          S_RDATA: begin
            if (w_scl_rise) begin
              w_bit_nxt = r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                w_state_nxt = S_MACK;
                w_mack_nxt  = 1'b0;
              end
            end else if (w_scl_fall) begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
            end
          end

          S_MACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
              end else begin
                w_mack_nxt = 1'b1;
              end
            end else if (w_scl_fall) begin
              if (r_mack_ok) begin
                w_state_nxt = S_RDATA;
                w_mack_nxt  = 1'b0;
                w_bit_nxt   = '0;
                w_shift_nxt = mem_rdata;
                w_oe_nxt    = ~mem_rdata[7];
                w_inc_nxt   = 1'b1;
              end else begin
                w_oe_nxt = 1'b0;
              end
            end
          end

          default: w_state_nxt = S_IDLE;
        endcase
      end
    endcase
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign mem_addr  = r_ptr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_eeprom_resp
// Description : Self-checking bench for i2c_eeprom_resp. A bit-banged I2C
//               master drives the bus; a byte-array EEPROM model with its own
//               address pointer predicts every ACK, read byte and write.
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_eeprom_resp;

  localparam int Q    = 8;       // clocks per quarter SCL period
  localparam int MEMS = 32768;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        scl_in, sda_in;
  logic        sda_oe, busy;
  logic [14:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;
  logic        mem_we;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_resp dut (
    .clk       (clk),
    .res       (res),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  // Backing RAM seen by the DUT, and the reference model contents
  logic [7:0]  ram   [0:MEMS-1];
  logic [7:0]  model [0:MEMS-1];
  logic [22:0] wq[$];              // observed writes {addr, data}
  int          ptr;                // model address pointer
  logic [7:0]  wbuf [0:7];

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      wq.push_back({mem_addr, mem_wdata});
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(2*Q);
    sda_m = 1'b0; clks(2*Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(2*Q);
    sda_m = 1'b1; clks(2*Q);
  endtask

  task automatic send_bit(input bit b);
    sda_m = b;    clks(Q);
    scl_m = 1'b1; clks(2*Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic get_bit(output bit b);
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    b = sda_in;   clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ack);
    bit x;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    get_bit(x);
    ack = ~x;
  endtask

  task automatic recv_byte(output logic [7:0] d, input bit last);
    bit x;
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      d[i] = x;
    end
    send_bit(last);
  endtask

  task automatic set_addr(input logic [15:0] a);
    bit ack;
    bus_start();
    send_byte(8'hA0, ack);   chk("addr_dev_ack", ack, 1);
    chk("busy_set", busy, 1);
    send_byte(a[15:8], ack); chk("addr_hi_ack", ack, 1);
    send_byte(a[7:0], ack);  chk("addr_lo_ack", ack, 1);
    ptr = int'(a[14:0]);
  endtask

  // Write wbuf[0..n-1] starting at address a
  task automatic do_write(input logic [15:0] a, input int n);
    bit          ack;
    logic [22:0] e;
    set_addr(a);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      chk("wr_data_ack", ack, 1);
    end
    bus_stop();
    chk("wr_busy_after_stop", busy, 0);
    chk("wr_count", wq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", e[22:8], ptr);
        chk("wr_data", e[7:0], wbuf[i]);
      end
      model[ptr] = wbuf[i];
      ptr = (ptr + 1) % MEMS;
    end
    wq.delete();
  endtask

  // Read n bytes; with_addr selects random vs current-address read
  task automatic do_read(input bit with_addr, input logic [15:0] a, input int n);
    bit         ack;
    logic [7:0] d;
    if (with_addr) set_addr(a);
    bus_start();
    send_byte(8'hA1, ack); chk("rd_dev_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, i == n-1);
      chk("rd_data", d, model[ptr]);
      ptr = (ptr + 1) % MEMS;
    end
    chk("rd_oe_released", sda_oe, 0);
    chk("rd_busy_after_nack", busy, 0);
    bus_stop();
    chk("rd_ptr", mem_addr, ptr);
    chk("rd_no_write", wq.size(), 0);
  endtask

  initial begin : main
    bit          ack, b;
    int          op, n;
    logic [15:0] a;

    for (int i = 0; i < MEMS; i++) begin
      model[i] = 8'($urandom);
      ram[i]   = model[i];
    end
    ptr = 0;

    // Reset state
    clks(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    res = 1'b0;
    clks(10);

    // Two-byte write at 0x0010
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    do_write(16'h0010, 2);

    // Random read back through a repeated START
    do_read(1'b1, 16'h0010, 2);
    chk("rd_ptr_0012", mem_addr, 15'h0012);

    // Wrong device address: no ACK, not busy, no write
    bus_start();
    send_byte(8'hA2, ack); chk("wrong_addr_ack", ack, 0);
    chk("wrong_addr_busy", busy, 0);
    send_byte(8'h00, ack); chk("wrong_addr_byte_ack", ack, 0);
    bus_stop();
    chk("wrong_addr_no_we", wq.size(), 0);

    // Sequential read across the top of memory
    do_read(1'b1, 16'h7FFF, 2);
    chk("wrap_ptr", mem_addr, 15'h0001);

    // Upper address bit ignored on a write
    wbuf[0] = 8'h5A;
    do_write(16'hFFFE, 1);

    // Reset during the 5th bit of a read of 0x00
    a = 16'(($urandom % MEMS) | 16'h0100);
    wbuf[0] = 8'h00;
    do_write(a, 1);
    set_addr(a);
    bus_start();
    send_byte(8'hA1, ack); chk("rst_rd_dev_ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      get_bit(b);
      chk("rst_rd_bit", b, 0);
    end
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    chk("rst_pre_oe", sda_oe, 1);
    #3 res = 1'b1;
    #1;
    chk("rst_mid_oe", sda_oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", mem_addr, 0);
    clks(4);
    res = 1'b0;
    ptr = 0;
    clks(20);
    do_read(1'b0, 16'h0000, 1);

    // STOP after 4 bits of a write data byte
    a = 16'($urandom);
    set_addr(a);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop();
    chk("abort_no_we", wq.size(), 0);
    chk("abort_busy", busy, 0);
    do_read(1'b0, 16'h0000, 1);
    wbuf[0] = 8'($urandom);
    do_write(a, 1);
    do_read(1'b1, a, 1);

    // Randomised mix of transactions
    for (int it = 0; it < 10; it++) begin
      op = int'($urandom_range(0, 2));
      a  = 16'($urandom);
      n  = int'($urandom_range(1, 3));
      if (op == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        do_write(a, n);
      end else begin
        do_read(op == 1, a, n);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
